sram_frame_arbiter: RTL and testbench

Sole owner of the single-port 16-bit frame-buffer SRAM; it shares the SRAM between three requesters: the display reader, the pixel writer and a built-in frame-clear engine. The display reader has absolute priority. The SRAM holds two frame banks, selected by address bit 19. The reader always sees the front bank; the writer and the clear engine always target the back bank. The banks swap only at a frame boundary. The block sits between the pixel-buffer writer / VGA reader logic and the top-level SRAM pins, which own the tristate.

---
 rtl/sram_frame_arbiter.sv | 170 +++++++++++++++++
 tb/tb_sram_frame_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_frame_arbiter.sv
// -----------------------------------------------------------------------------
// sram_frame_arbiter
//
// Owns the single-port 16-bit frame-buffer SRAM and shares it between the
// display reader, the pixel writer and a built-in clear engine. The reader
// always wins. Address bit ADDR_W selects one of two frame banks: reads go to
// the front bank; writer and clear engine go to the back bank. Banks swap only
// on frame_start, and never while a clear is running.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   rd_req, rd_addr, rd_data      display reader (never denied)
//   wr_valid/ready/addr/data/ub/lb pixel writer, zero-latency handshake
//   frame_start, swap_req         bank swap control
//   swap_pending, front_sel       bank swap status
//   clear_start, clear_data       clear engine control / fill word
//   clear_busy, clear_done        clear engine status
//   sram_*                        SRAM pins (tristate owned by the top level)
// -----------------------------------------------------------------------------
module sram_frame_arbiter #(
    parameter int                ADDR_W      = 19,
    parameter logic [ADDR_W-1:0] CLEAR_WORDS = 19'd460800
) (
    input  logic              clk,
    input  logic              rst,
    // display reader
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [15:0]       rd_data,
    // pixel writer
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [15:0]       wr_data,
    input  logic              wr_ub,
    input  logic              wr_lb,
    // bank swap
    input  logic              frame_start,
    input  logic              swap_req,
    output logic              swap_pending,
    output logic              front_sel,
    // clear engine
    input  logic              clear_start,
    input  logic [15:0]       clear_data,
    output logic              clear_busy,
    output logic              clear_done,
    // SRAM pins
    output logic              sram_re,
    output logic              sram_we,
    output logic [ADDR_W:0]   sram_addr,
    output logic              sram_ub,
    output logic              sram_lb,
    output logic [15:0]       sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [15:0]       sram_dq_in
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_next;
    logic              front_next, pending_next, done_next;
    logic              clear_grant;
    logic              we_grant;

    // The clear engine only advances on cycles the reader leaves free.
    assign clear_grant = (state == CLEAR) && !rd_req;

    // -------------------------------------------------------------------------
    // Grant / SRAM pin mux
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        sram_re     = 1'b0;
        we_grant    = 1'b0;
        sram_addr   = '0;
        sram_ub     = 1'b0;
        sram_lb     = 1'b0;
        sram_dq_out = '0;
        if (rd_req) begin
            sram_re   = 1'b1;
            sram_addr = {front_sel, rd_addr};
            sram_ub   = 1'b1;
            sram_lb   = 1'b1;
        end else if (state == CLEAR) begin
            we_grant    = 1'b1;
            sram_addr   = {~front_sel, clr_cnt};
            sram_dq_out = clear_data;
            sram_ub     = 1'b1;
            sram_lb     = 1'b1;
        end else if (wr_valid) begin
            we_grant    = 1'b1;
            sram_addr   = {~front_sel, wr_addr};
            sram_dq_out = wr_data;
            sram_ub     = wr_ub;
            sram_lb     = wr_lb;
        end
    end

    // Reset blocks writes so a clear interrupted by reset cannot touch SRAM.
    assign sram_we    = we_grant && !rst;
    assign sram_dq_oe = sram_we;
    assign wr_ready   = !rd_req && (state == IDLE) && !rst;
    assign rd_data    = sram_dq_in;
    assign clear_busy = (state == CLEAR);

    // -------------------------------------------------------------------------
    // Next-state logic: clear engine and bank swap
    // -------------------------------------------------------------------------
    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        done_next    = 1'b0;
        front_next   = front_sel;
        pending_next = swap_pending;

        case (state)
            IDLE: begin
                if (clear_start) begin
                    state_next   = CLEAR;
                    clr_cnt_next = '0;
                end
            end
            CLEAR: begin
                if (clear_grant) begin
                    if (clr_cnt == CLEAR_WORDS - ADDR_W'(1)) begin
                        state_next   = IDLE;
                        clr_cnt_next = '0;
                        done_next    = 1'b1;
                    end else begin
                        clr_cnt_next = clr_cnt + ADDR_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // A swap waits out a running clear so the back bank never changes
        // underneath it. A swap_req coinciding with the swap edge is absorbed.
        if (frame_start && swap_pending && (state == IDLE)) begin
            front_next   = ~front_sel;
            pending_next = 1'b0;
        end else if (swap_req) begin
            pending_next = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (rst) begin
            state        <= IDLE;
            clr_cnt      <= '0;
            front_sel    <= 1'b0;
            swap_pending <= 1'b0;
            clear_done   <= 1'b0;
        end else begin
            state        <= state_next;
            clr_cnt      <= clr_cnt_next;
            front_sel    <= front_next;
            swap_pending <= pending_next;
            clear_done   <= done_next;
        end
    end

endmodule

// File: tb/tb_sram_frame_arbiter.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for sram_frame_arbiter. Each cycle the stimulus process
// advances a behavioural model, drives new inputs, and queues the outputs the
// model expects for that cycle. A monitor pops and compares on the falling
// edge. Directed scenarios come first, then a long randomized run.
// -----------------------------------------------------------------------------
module tb_sram_frame_arbiter;

    localparam int          ADDR_W = 19;
    localparam logic [18:0] CW     = 19'd8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_req = 0, wr_valid = 0, wr_ub = 0, wr_lb = 0;
    logic [18:0] rd_addr = '0, wr_addr = '0;
    logic [15:0] wr_data = '0, clear_data = '0, sram_dq_in = '0;
    logic        frame_start = 0, swap_req = 0, clear_start = 0;
    logic [15:0] rd_data, sram_dq_out;
    logic        wr_ready, swap_pending, front_sel, clear_busy, clear_done;
    logic        sram_re, sram_we, sram_ub, sram_lb, sram_dq_oe;
    logic [19:0] sram_addr;

    sram_frame_arbiter #(.ADDR_W(ADDR_W), .CLEAR_WORDS(CW)) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ub(wr_ub), .wr_lb(wr_lb),
        .frame_start(frame_start), .swap_req(swap_req),
        .swap_pending(swap_pending), .front_sel(front_sel),
        .clear_start(clear_start), .clear_data(clear_data),
        .clear_busy(clear_busy), .clear_done(clear_done),
        .sram_re(sram_re), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_ub(sram_ub), .sram_lb(sram_lb), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        re, we, oe;
        logic [19:0] addr;
        logic [15:0] dq_out;
        logic        ub, lb;
        logic        wr_ready, front_sel, swap_pending, clear_busy, clear_done;
        logic [15:0] rd_data;
    } obs_t;

    typedef struct {
        logic        rst, rd_req, wr_valid, wr_ub, wr_lb;
        logic [18:0] rd_addr, wr_addr;
        logic [15:0] wr_data, clear_data, dq_in;
        logic        frame_start, swap_req, clear_start;
    } stim_t;

    obs_t exp_q[$];
    int   checks = 0, failures = 0, cyc_n = 0;
    bit   started = 0;

    // Behavioural model state: plain integers/bits, not the DUT encoding.
    bit m_front, m_pending, m_clearing, m_done;
    int m_idx;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc_n, got, want);
        end
    endtask

    // Apply the inputs that were present at the edge that just happened.
    task automatic model_step();
        bit was_clearing;
        was_clearing = m_clearing;
        if (rst) begin
            m_front = 0; m_pending = 0; m_clearing = 0; m_done = 0; m_idx = 0;
            return;
        end
        m_done = 0;
        if (m_clearing) begin
            if (!rd_req) begin
                if (m_idx == int'(CW) - 1) begin
                    m_clearing = 0; m_idx = 0; m_done = 1;
                end else m_idx++;
            end
        end else if (clear_start) begin
            m_clearing = 1; m_idx = 0;
        end
        if (frame_start && m_pending && !was_clearing) begin
            m_front = !m_front; m_pending = 0;
        end else if (swap_req) m_pending = 1;
    endtask

    function automatic obs_t model_out();
        obs_t e;
        e = '0;
        if (rd_req) begin
            e.re = 1; e.addr = {m_front, rd_addr}; e.ub = 1; e.lb = 1;
        end else if (m_clearing) begin
            e.we = 1; e.addr = {!m_front, 19'(m_idx)}; e.dq_out = clear_data;
            e.ub = 1; e.lb = 1;
        end else if (wr_valid) begin
            e.we = 1; e.addr = {!m_front, wr_addr}; e.dq_out = wr_data;
            e.ub = wr_ub; e.lb = wr_lb;
        end
        if (rst) e.we = 0;
        e.oe           = e.we;
        e.wr_ready     = !rd_req && !m_clearing && !rst;
        e.front_sel    = m_front;
        e.swap_pending = m_pending;
        e.clear_busy   = m_clearing;
        e.clear_done   = m_done;
        e.rd_data      = sram_dq_in;
        return e;
    endfunction

    function automatic stim_t quiet();
        stim_t s;
        s.rst = 0; s.rd_req = 0; s.wr_valid = 0;
        s.wr_ub = 1'($urandom); s.wr_lb = 1'($urandom);
        s.rd_addr = 19'($urandom); s.wr_addr = 19'($urandom);
        s.wr_data = 16'($urandom); s.clear_data = 16'($urandom);
        s.dq_in = 16'($urandom);
        s.frame_start = 0; s.swap_req = 0; s.clear_start = 0;
        return s;
    endfunction

    task automatic cyc(input stim_t s);
        @(posedge clk);
        #1;
        model_step();
        rst = s.rst; rd_req = s.rd_req; rd_addr = s.rd_addr;
        wr_valid = s.wr_valid; wr_addr = s.wr_addr; wr_data = s.wr_data;
        wr_ub = s.wr_ub; wr_lb = s.wr_lb; clear_data = s.clear_data;
        sram_dq_in = s.dq_in; frame_start = s.frame_start;
        swap_req = s.swap_req; clear_start = s.clear_start;
        exp_q.push_back(model_out());
        started = 1;
    endtask

    // Monitor: every cycle the DUT presents a fresh set of outputs.
    initial begin
        obs_t got, want;
        forever begin
            @(negedge clk);
            if (started) begin
                cyc_n++;
                got = {sram_re, sram_we, sram_dq_oe, sram_addr, sram_dq_out,
                       sram_ub, sram_lb, wr_ready, front_sel, swap_pending,
                       clear_busy, clear_done, rd_data};
                if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", 128'(1), 128'(0));
                end else begin
                    want = exp_q.pop_front();
                    check("outputs", 128'(got), 128'(want));
                end
            end
        end
    end

    initial begin
        stim_t s;
        // Reset
        s = quiet(); s.rst = 1; cyc(s); cyc(s);
        // Read beats write, then write goes to back bank
        s = quiet(); s.rd_req = 1; s.rd_addr = 19'h00010; s.wr_valid = 1; cyc(s);
        s.rd_req = 0; cyc(s);
        // Clear of 8 words, reader stalls it twice, writer waiting throughout
        s = quiet(); s.clear_start = 1; s.wr_valid = 1; cyc(s);
        for (int i = 0; i < 13; i++) begin
            s = quiet(); s.wr_valid = 1; s.rd_req = (i == 2 || i == 3);
            s.clear_start = (i == 4);
            cyc(s);
        end
        // Swap request, frame_start five cycles later
        s = quiet(); s.swap_req = 1; cyc(s);
        for (int i = 0; i < 4; i++) begin s = quiet(); cyc(s); end
        s = quiet(); s.frame_start = 1; cyc(s);
        s = quiet(); s.rd_req = 1; cyc(s);
        s = quiet(); s.wr_valid = 1; cyc(s);
        // swap_req and frame_start together: no toggle until next frame_start
        s = quiet(); s.swap_req = 1; s.frame_start = 1; cyc(s);
        s = quiet(); cyc(s);
        s = quiet(); s.frame_start = 1; cyc(s);
        s = quiet(); s.wr_valid = 1; cyc(s);
        // frame_start during clear does not swap; next one after clear does
        s = quiet(); s.swap_req = 1; s.clear_start = 1; cyc(s);
        for (int i = 0; i < 10; i++) begin
            s = quiet(); s.frame_start = (i == 3); s.wr_valid = 1; cyc(s);
        end
        s = quiet(); s.frame_start = 1; cyc(s);
        // clear_start with swapping frame_start: clear lands on new back bank
        s = quiet(); s.swap_req = 1; cyc(s);
        s = quiet(); s.frame_start = 1; s.clear_start = 1; cyc(s);
        for (int i = 0; i < 9; i++) begin s = quiet(); cyc(s); end
        // Reset mid-clear after three granted writes
        s = quiet(); s.swap_req = 1; cyc(s);
        s = quiet(); s.frame_start = 1; cyc(s);
        s = quiet(); s.clear_start = 1; cyc(s);
        for (int i = 0; i < 3; i++) begin s = quiet(); cyc(s); end
        s = quiet(); s.rst = 1; cyc(s);
        s = quiet(); cyc(s);
        s = quiet(); cyc(s);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            s = quiet();
            s.rd_req      = ($urandom_range(99) < 40);
            s.wr_valid    = ($urandom_range(99) < 60);
            s.frame_start = ($urandom_range(99) < 6);
            s.swap_req    = ($urandom_range(99) < 6);
            s.clear_start = ($urandom_range(99) < 3);
            s.rst         = ($urandom_range(999) < 5);
            cyc(s);
        end
        // Let the monitor consume the last entry, bounded wait
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
